// File: rtl/serial_bus_arbiter_pkg.sv
// Shared constants for the multi-master serial bus arbiter: FSM encoding and width helpers.
package serial_bus_arbiter_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_GRANT   = 3'd1;
  localparam logic [STATE_W-1:0] ST_ADDR    = 3'd2;
  localparam logic [STATE_W-1:0] ST_DECODE  = 3'd3;
  localparam logic [STATE_W-1:0] ST_CONNECT = 3'd4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) res++;
    return res;
  endfunction

  // Index width that stays at least one bit wide for single-entry ranges.
  function automatic int unsigned idx_w(input int unsigned value);
    return (clog2(value) == 0) ? 1 : clog2(value);
  endfunction

endpackage

// File: rtl/serial_bus_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after i_rr_ptr, wrapping.
module rr_arbiter
  import serial_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned IDX_W       = idx_w(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [IDX_W-1:0]       i_rr_ptr,
  output logic [NUM_MASTERS-1:0] o_onehot,
  output logic [IDX_W-1:0]       o_idx,
  output logic                   o_valid
);

  logic [2*NUM_MASTERS-1:0] w_dbl;
  logic [NUM_MASTERS-1:0]   w_rot;
  logic                     w_found;
  int unsigned              w_pos;

  // Rotate so bit 0 is the master just after the pointer, then take the lowest set bit.
  always_comb begin
    w_dbl   = {i_req, i_req};
    w_rot   = NUM_MASTERS'(w_dbl >> (32'(i_rr_ptr) + 32'd1));
    w_found = 1'b0;
    w_pos   = 0;
    for (int unsigned j = 0; j < NUM_MASTERS; j++) begin
      if (!w_found && w_rot[j]) begin
        w_found = 1'b1;
        w_pos   = 32'(i_rr_ptr) + j + 32'd1;
      end
    end
    if (w_pos >= NUM_MASTERS) w_pos = w_pos - NUM_MASTERS;
    o_valid  = w_found;
    o_idx    = IDX_W'(w_pos);
    o_onehot = w_found ? (NUM_MASTERS'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/serial_bus_arbiter.sv
// Round-robin multi-master serial bus arbiter with serial slave-address decode and routing.
module serial_bus_arbiter
  import serial_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned NUM_SLAVES  = 3,
  parameter int unsigned SADDR_W     = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] m_req,
  output logic [NUM_MASTERS-1:0] m_grant,
  input  logic [NUM_MASTERS-1:0] m_address_valid,
  input  logic [NUM_MASTERS-1:0] m_address,
  input  logic [NUM_MASTERS-1:0] m_data,
  input  logic [NUM_MASTERS-1:0] m_valid,
  output logic [NUM_MASTERS-1:0] m_ready,
  output logic [NUM_MASTERS-1:0] m_error,
  output logic [NUM_SLAVES-1:0]  s_address,
  output logic [NUM_SLAVES-1:0]  s_data,
  output logic [NUM_SLAVES-1:0]  s_valid,
  input  logic [NUM_SLAVES-1:0]  s_ready
);

  localparam int unsigned IDX_W = idx_w(NUM_MASTERS);
  localparam int unsigned CNT_W = idx_w(SADDR_W);

  if (NUM_SLAVES > (2 ** SADDR_W)) begin : g_cfg_check
    $error("serial_bus_arbiter: NUM_SLAVES exceeds the SADDR_W address space");
  end

  logic [STATE_W-1:0]     r_state, w_state_nxt;
  logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
  logic [IDX_W-1:0]       r_rr_ptr, w_rr_ptr_nxt;
  logic [SADDR_W-1:0]     r_addr_buf, w_addr_buf_nxt;
  logic [SADDR_W-1:0]     r_sel, w_sel_nxt;
  logic [CNT_W-1:0]       r_bit_cnt, w_bit_cnt_nxt;

  logic [NUM_MASTERS-1:0] w_arb_onehot;
  logic [IDX_W-1:0]       w_arb_idx;
  logic                   w_arb_valid;

  logic                   w_g_req, w_g_av, w_g_addr, w_g_data, w_g_valid;
  logic                   w_addr_ok, w_last_bit, w_route, w_s_rdy;
  logic [NUM_SLAVES-1:0]  w_sel_onehot;

  rr_arbiter #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_rr_arbiter (
    .i_req    (m_req),
    .i_rr_ptr (r_rr_ptr),
    .o_onehot (w_arb_onehot),
    .o_idx    (w_arb_idx),
    .o_valid  (w_arb_valid)
  );

  // Grant is one-hot, so masking and OR-reducing selects the granted master's lines.
  assign w_g_req    = |(m_req & r_grant);
  assign w_g_av     = |(m_address_valid & r_grant);
  assign w_g_addr   = |(m_address & r_grant);
  assign w_g_data   = |(m_data & r_grant);
  assign w_g_valid  = |(m_valid & r_grant);

  assign w_addr_ok  = (32'(r_addr_buf) < NUM_SLAVES);
  assign w_last_bit = (32'(r_bit_cnt) == (SADDR_W - 1));

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_addr_buf_nxt = r_addr_buf;
    w_sel_nxt      = r_sel;
    w_bit_cnt_nxt  = r_bit_cnt;
    if ((r_state != ST_IDLE) && !w_g_req) begin
      w_state_nxt = ST_IDLE;
      w_grant_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_arb_valid) begin
            w_grant_nxt  = w_arb_onehot;
            w_rr_ptr_nxt = w_arb_idx;
            w_state_nxt  = ST_GRANT;
          end
        end
        ST_GRANT, ST_CONNECT: begin
          if (w_g_av) begin
            w_state_nxt   = ST_ADDR;
            w_bit_cnt_nxt = '0;
          end
        end
        ST_ADDR: begin
          w_addr_buf_nxt = SADDR_W'({r_addr_buf, w_g_addr});
          w_bit_cnt_nxt  = r_bit_cnt + CNT_W'(1);
          if (w_last_bit) w_state_nxt = ST_DECODE;
        end
        ST_DECODE: begin
          if (w_addr_ok) begin
            w_sel_nxt   = r_addr_buf;
            w_state_nxt = ST_CONNECT;
          end else begin
            w_state_nxt = ST_GRANT;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_addr_buf <= '0;
      r_sel      <= '0;
      r_bit_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_addr_buf <= w_addr_buf_nxt;
      r_sel      <= w_sel_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
    end
  end

  // A re-address strobe in CONNECT cuts routing in the same cycle.
  assign w_route      = (r_state == ST_CONNECT) && !w_g_av;
  assign w_sel_onehot = NUM_SLAVES'(1) << r_sel;
  assign w_s_rdy      = |(s_ready & w_sel_onehot);

  assign m_grant   = r_grant;
  assign m_ready   = (w_route && w_s_rdy) ? r_grant : '0;
  assign m_error   = ((r_state == ST_DECODE) && !w_addr_ok) ? r_grant : '0;
  assign s_address = (w_route && w_g_addr)  ? w_sel_onehot : '0;
  assign s_data    = (w_route && w_g_data)  ? w_sel_onehot : '0;
  assign s_valid   = (w_route && w_g_valid) ? w_sel_onehot : '0;

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Directed bench: cycle vector table on the default build plus hand sequences and a wide build.
module tb_serial_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default build: 2 masters, 3 slaves, 2-bit address
  logic       reset;
  logic [1:0] m_req, m_grant, m_av, m_addr, m_data, m_valid, m_ready, m_error;
  logic [2:0] s_addr, s_data, s_valid, s_ready;

  serial_bus_arbiter u_dut (
    .clk(clk), .reset(reset),
    .m_req(m_req), .m_grant(m_grant), .m_address_valid(m_av),
    .m_address(m_addr), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_error(m_error),
    .s_address(s_addr), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready)
  );

  // Wide build: 4 masters, 8 slaves, 3-bit address
  logic       b_reset;
  logic [3:0] b_req, b_grant, b_av, b_addr, b_data, b_valid, b_ready, b_error;
  logic [7:0] b_saddr, b_sdata, b_svalid, b_sready;

  serial_bus_arbiter #(.NUM_MASTERS(4), .NUM_SLAVES(8), .SADDR_W(3)) u_dut_wide (
    .clk(clk), .reset(b_reset),
    .m_req(b_req), .m_grant(b_grant), .m_address_valid(b_av),
    .m_address(b_addr), .m_data(b_data), .m_valid(b_valid),
    .m_ready(b_ready), .m_error(b_error),
    .s_address(b_saddr), .s_data(b_sdata), .s_valid(b_svalid), .s_ready(b_sready)
  );

  typedef struct packed {
    logic [1:0] req, av, addr, data, valid;
    logic [2:0] srdy;
    logic [1:0] grant, ready, err;
    logic [2:0] sa, sd, sv;
  } vec_t;

  localparam int NV = 32;
  vec_t vecs [NV];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [1:0] req, av, addr, data, valid, input logic [2:0] srdy,
                              input logic [1:0] grant, ready, err, input logic [2:0] sa, sd, sv);
    vec_t v;
    v = '{req, av, addr, data, valid, srdy, grant, ready, err, sa, sd, sv};
    return v;
  endfunction

  function automatic logic [63:0] small_outs();
    return 64'({m_grant, m_ready, m_error, s_addr, s_data, s_valid});
  endfunction

  task automatic wide_wait_grant(input string name, input logic [3:0] exp);
    for (int c = 0; c < 8 && b_grant == 4'b0; c++) tick();
    chk(name, 64'(b_grant), 64'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; m_req = '0; m_av = '0; m_addr = '0; m_data = '0; m_valid = '0; s_ready = '0;
    b_reset = 1'b1; b_req = '0; b_av = '0; b_addr = '0; b_data = '0; b_valid = '0; b_sready = '0;

    //                req    av     addr   data   valid  srdy     grant  ready  err    sa      sd      sv
    vecs[0]  = mk(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000,  2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000);
    vecs[1]  = mk(2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000,  2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000);
    vecs[2]  = mk(2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000,  2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000);
    vecs[3]  = mk(2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 3'b000,  2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000);
    vecs[4]  = mk(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000,  2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000);
    vecs[5]  = mk(2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 3'b010,  2'b01, 2'b01, 2'b00, 3'b010, 3'b010, 3'b010);
    vecs[6]  = mk(2'b01, 2'b00, 2'b10, 2'b10, 2'b11, 3'b101,  2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 3'b010);
    vecs[7]  = mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b010,  2'b01, 2'b01, 2'b00, 3'b000, 3'b000, 3'b000);
    vecs[8]  = mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000,  2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000);
    vecs[9]  = mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000,  2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000);
    vecs[10] = mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000,  2'b10, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000);
    vecs[11] = mk(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000,  2'b10, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000);
    vecs[12] = mk(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000,  2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000);
    vecs[13] = mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000,  2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000);
    vecs[14] = mk(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000,  2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000);
    vecs[15] = mk(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000,  2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000);
    vecs[16] = mk(2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 3'b000,  2'b10, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000);
    vecs[17] = mk(2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000,  2'b10, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000);
    vecs[18] = mk(2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000,  2'b10, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000);
    vecs[19] = mk(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000,  2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 3'b000);
    vecs[20] = mk(2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 3'b000,  2'b10, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000);
    vecs[21] = mk(2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000,  2'b10, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000);
    vecs[22] = mk(2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 3'b000,  2'b10, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000);
    vecs[23] = mk(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000,  2'b10, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000);
    vecs[24] = mk(2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 3'b100,  2'b10, 2'b10, 2'b00, 3'b100, 3'b000, 3'b100);
    vecs[25] = mk(2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 3'b100,  2'b10, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000);
    vecs[26] = mk(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000,  2'b10, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000);
    vecs[27] = mk(2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000,  2'b10, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000);
    vecs[28] = mk(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000,  2'b10, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000);
    vecs[29] = mk(2'b10, 2'b00, 2'b00, 2'b10, 2'b10, 3'b010,  2'b10, 2'b10, 2'b00, 3'b000, 3'b010, 3'b010);
    vecs[30] = mk(2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 3'b010,  2'b10, 2'b10, 2'b00, 3'b000, 3'b010, 3'b010);
    vecs[31] = mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000,  2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000);

    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    chk("reset_state", small_outs(), 64'd0);
    tick();

    // Cycle-by-cycle table: inputs held for one cycle, outputs checked mid-cycle
    for (int k = 0; k < NV; k++) begin
      m_req = vecs[k].req; m_av = vecs[k].av; m_addr = vecs[k].addr;
      m_data = vecs[k].data; m_valid = vecs[k].valid; s_ready = vecs[k].srdy;
      @(negedge clk);
      chk($sformatf("vec%0d", k), small_outs(),
          64'({vecs[k].grant, vecs[k].ready, vecs[k].err, vecs[k].sa, vecs[k].sd, vecs[k].sv}));
      tick();
    end
    m_req = '0; m_av = '0; m_addr = '0; m_data = '0; m_valid = '0; s_ready = '0;
    tick();

    // Reset while shifting the address
    m_req = 2'b01; tick();
    m_av = 2'b01; tick();
    m_av = 2'b00; m_addr = 2'b01; tick();
    reset = 1'b1; tick();
    reset = 1'b0; m_addr = 2'b00;
    @(negedge clk);
    chk("reset_in_addr", small_outs(), 64'd0);
    tick();
    @(negedge clk);
    chk("regrant_after_reset", 64'(m_grant), 64'(2'b01));

    // Reset while connected to slave 2, then both request: master 1 wins
    m_av = 2'b01; tick();
    m_av = 2'b00; m_addr = 2'b01; tick();
    m_addr = 2'b00; tick();
    tick();
    m_valid = 2'b01; m_data = 2'b01; s_ready = 3'b100;
    @(negedge clk);
    chk("connect_slave2", small_outs(), 64'({2'b01, 2'b01, 2'b00, 3'b000, 3'b100, 3'b100}));
    reset = 1'b1; tick();
    reset = 1'b0; m_req = 2'b11; m_valid = '0; m_data = '0;
    @(negedge clk);
    chk("reset_in_connect", small_outs(), 64'd0);
    tick();
    @(negedge clk);
    chk("priority_after_reset", 64'(m_grant), 64'(2'b10));

    // Release and address strobe in the same cycle: release wins
    m_req = 2'b01; m_av = 2'b10; tick();
    m_av = 2'b00;
    @(negedge clk);
    chk("release_beats_strobe", 64'(m_grant), 64'(2'b00));
    tick();
    @(negedge clk);
    chk("next_winner_m0", 64'(m_grant), 64'(2'b01));
    m_req = '0; s_ready = '0;

    // Wide build: round-robin order under full load
    tick();
    b_reset = 1'b0; b_req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wide_wait_grant($sformatf("wide_rr%0d", i), 4'b0001 << ((i + 1) % 4));
      b_req = 4'b1111 & ~b_grant; tick();
      b_req = 4'b1111;
    end
    b_req = 4'b0000; tick(); tick();

    // Wide build: every slave address reachable from master 2
    for (int a = 0; a < 8; a++) begin
      logic [2:0] abits;
      abits = 3'(a);
      b_req = 4'b0100;
      wide_wait_grant($sformatf("wide_grant%0d", a), 4'b0100);
      b_av = 4'b0100; tick();
      b_av = 4'b0000;
      for (int i = 2; i >= 0; i--) begin
        b_addr = {1'b0, abits[i], 2'b00}; tick();
      end
      b_addr = 4'b0000; tick();
      b_valid = 4'b0100; b_data = 4'b0100; b_sready = 8'd1 << a;
      @(negedge clk);
      chk($sformatf("wide_slave%0d", a), 64'({b_svalid, b_sdata, b_saddr, b_ready, b_error}),
          64'({8'd1 << a, 8'd1 << a, 8'd0, 4'b0100, 4'b0000}));
      b_req = 4'b0000; b_valid = '0; b_data = '0; b_sready = '0;
      tick(); tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
